// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR controller slice.
package sar_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DECIDE = 2'd2,
        S_DONE   = 2'd3
    } sar_state_t;

    // Fewest flops allowed in the comparator synchronizer.
    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flip-flop synchronizer for a single asynchronous bit.
module sync_ff
    import sar_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation ADC controller with a ramp-compare
// capture mode. Optional build macro SAR_CTRL_AUTO_RESTART_EN makes DONE start
// the next conversion directly while enable and adc_mode stay high.
module sar_controller
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             adc_mode,
    input  logic             start,
    input  logic             comparator_in,
    output logic [WIDTH-1:0] sar_duty_cycle,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             capture_en
);

    if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
        $error("sar_controller: SETTLE_CYCLES must be >= SYNC_STAGES+1");
    end

    localparam int unsigned     IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned     CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

    sar_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_trial, w_trial_nxt, w_trial_dec;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_dn;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_comp_s;
    logic             r_comp_prev;
    logic             w_run;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (comparator_in),
        .o_q     (w_comp_s)
    );

    assign w_run    = enable & adc_mode;
    assign w_idx_dn = r_idx - IDX_W'(1);

    // Next-state, trial, counter and result logic for the SAR sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_trial_dec  = r_trial;
        if (!w_comp_s) begin
            w_trial_dec[r_idx] = 1'b0;
        end
        case (r_state)
            S_IDLE: begin
                if (start && w_run) begin
                    w_state_nxt = S_SETTLE;
                    w_trial_nxt = TRIAL_MSB;
                    w_idx_nxt   = IDX_MSB;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DECIDE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DECIDE: begin
                w_trial_nxt = w_trial_dec;
                if (r_idx == '0) begin
                    // Result is loaded on entry to DONE so it is valid alongside the done pulse.
                    w_result_nxt = w_trial_dec;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_trial_nxt[w_idx_dn] = 1'b1;
                    w_idx_nxt             = w_idx_dn;
                    w_cnt_nxt             = CNT_LOAD;
                    w_state_nxt           = S_SETTLE;
                end
            end
            S_DONE: begin
`ifdef SAR_CTRL_AUTO_RESTART_EN
                if (w_run) begin
                    w_state_nxt = S_SETTLE;
                    w_trial_nxt = TRIAL_MSB;
                    w_idx_nxt   = IDX_MSB;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Dropping enable or leaving SAR mode abandons any conversion in flight.
        if (r_state != S_IDLE && !w_run) begin
            w_state_nxt  = S_IDLE;
            w_trial_nxt  = '0;
            w_idx_nxt    = '0;
            w_cnt_nxt    = '0;
            w_result_nxt = r_result;
        end
    end

    // State and datapath registers; comparator history tracks comp_s continuously.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_trial     <= '0;
            r_result    <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_comp_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_trial     <= w_trial_nxt;
            r_result    <= w_result_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_comp_prev <= w_comp_s;
        end
    end

    assign sar_duty_cycle = r_trial;
    assign result         = r_result;
    assign done           = (r_state == S_DONE);
    assign busy           = (r_state != S_IDLE);
    assign capture_en     = enable & ~adc_mode & w_comp_s & ~r_comp_prev;

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: directed bench for sar_controller (WIDTH=8, SETTLE_CYCLES=4).
module tb_sar_controller;

    logic       clk = 1'b0;
    logic       reset, enable, adc_mode, start, comparator_in;
    logic [7:0] duty, result;
    logic       done, busy, capture_en;
    logic [7:0] vin;
    logic       use_model, ramp_val;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    // Behavioural comparator, or a directly driven level in ramp tests.
    assign comparator_in = use_model ? (vin >= duty) : ramp_val;

    sar_controller #(.WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .adc_mode       (adc_mode),
        .start          (start),
        .comparator_in  (comparator_in),
        .sar_duty_cycle (duty),
        .result         (result),
        .done           (done),
        .busy           (busy),
        .capture_en     (capture_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; adc_mode = 1'b1; start = 1'b0;
        use_model = 1'b1; vin = 8'h00; ramp_val = 1'b0;
        tick(); tick();
        n_total++; if (duty !== 8'h00) $display("FAIL reset_duty: got %h want 00", duty); else n_pass++;
        n_total++; if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (capture_en !== 1'b0) $display("FAIL reset_capture: got %b want 0", capture_en); else n_pass++;
        reset = 1'b0;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_sar_a5();
        logic [7:0] seq [8];
        logic [7:0] res_at;
        int dones, done_at;
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        dones = 0; done_at = -1; res_at = 8'h00;
        vin = 8'hA5;
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 1; m <= 46; m++) begin
            if (m == 1) begin
                n_total++; if (busy !== 1'b1) $display("FAIL a5_busy: got %b want 1", busy); else n_pass++;
            end
            if ((m % 5) == 1 && m <= 36) begin
                n_total++;
                if (duty !== seq[(m - 1) / 5]) $display("FAIL a5_trial%0d: got %h want %h", (m - 1) / 5, duty, seq[(m - 1) / 5]);
                else n_pass++;
            end
            if (done === 1'b1) begin dones++; done_at = m; res_at = result; end
            tick();
        end
        n_total++; if (dones != 1) $display("FAIL a5_done_count: got %0d want 1", dones); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL a5_done_latency: got %0d want 41", done_at); else n_pass++;
        n_total++; if (res_at !== 8'hA5) $display("FAIL a5_result: got %h want a5", res_at); else n_pass++;
`ifndef SAR_CTRL_AUTO_RESTART_EN
        n_total++; if (duty !== 8'hA5) $display("FAIL a5_duty_hold: got %h want a5", duty); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL a5_idle_after: got %b want 0", busy); else n_pass++;
`endif
        enable = 1'b0; tick(); enable = 1'b1; tick();
    endtask

    task automatic test_abort_mode();
        int dones;
        dones = 0;
        vin = 8'h5A;
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 1; m < 20; m++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        adc_mode = 1'b0;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL mode_abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (duty !== 8'h00) $display("FAIL mode_abort_duty: got %h want 00", duty); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mode_abort_done: got %b want 0", done); else n_pass++;
        n_total++; if (result !== 8'hA5) $display("FAIL mode_abort_result: got %h want a5", result); else n_pass++;
        adc_mode = 1'b1;
        for (int m = 0; m < 50; m++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_total++; if (dones != 0) $display("FAIL mode_abort_no_done: got %0d want 0", dones); else n_pass++;
    endtask

    task automatic test_boundary();
        logic [7:0] vins [2];
        logic [7:0] res_at;
        int dones;
        vins = '{8'hFF, 8'h00};
        for (int k = 0; k < 2; k++) begin
            dones = 0; res_at = 8'hxx;
            vin = vins[k];
            start = 1'b1; tick(); start = 1'b0;
            for (int m = 1; m <= 46; m++) begin
                if (done === 1'b1) begin dones++; res_at = result; end
                tick();
            end
            n_total++; if (dones != 1) $display("FAIL boundary%0d_done_count: got %0d want 1", k, dones); else n_pass++;
            n_total++; if (res_at !== vins[k]) $display("FAIL boundary%0d_result: got %h want %h", k, res_at, vins[k]); else n_pass++;
            enable = 1'b0; tick(); enable = 1'b1; tick();
        end
    endtask

    task automatic test_abort_reset();
        int dones;
        dones = 0;
        vin = 8'hA5;
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 1; m < 20; m++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        reset = 1'b1;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (duty !== 8'h00) $display("FAIL reset_abort_duty: got %h want 00", duty); else n_pass++;
        n_total++; if (result !== 8'h00) $display("FAIL reset_abort_result: got %h want 00", result); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_abort_done: got %b want 0", done); else n_pass++;
        n_total++; if (capture_en !== 1'b0) $display("FAIL reset_abort_capture: got %b want 0", capture_en); else n_pass++;
        reset = 1'b0;
        for (int m = 0; m < 50; m++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_total++; if (dones != 0) $display("FAIL reset_abort_no_done: got %0d want 0", dones); else n_pass++;
    endtask

    task automatic test_start_held();
        logic [7:0] res_at;
        int dones, done_at;
        dones = 0; done_at = -1; res_at = 8'h00;
        vin = 8'h3C;
        start = 1'b1; tick();
        for (int m = 1; m <= 60; m++) begin
            if (m == 3) start = 1'b0;
            if (done === 1'b1) begin dones++; done_at = m; res_at = result; end
            tick();
        end
        n_total++; if (dones != 1) $display("FAIL held_done_count: got %0d want 1", dones); else n_pass++;
        n_total++; if (done_at != 41) $display("FAIL held_done_latency: got %0d want 41", done_at); else n_pass++;
        n_total++; if (res_at !== 8'h3C) $display("FAIL held_result: got %h want 3c", res_at); else n_pass++;
        enable = 1'b0; tick(); enable = 1'b1; tick();
    endtask

    task automatic test_ramp();
        int pulses, first, total;
        total = 0;
        ramp_val = 1'b0; use_model = 1'b0; adc_mode = 1'b0;
        for (int m = 0; m < 4; m++) tick();
        n_total++; if (capture_en !== 1'b0) $display("FAIL ramp_quiet: got %b want 0", capture_en); else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL ramp_start_ignored: got %b want 0", busy); else n_pass++;
        for (int e = 0; e < 3; e++) begin
            pulses = 0; first = -1;
            ramp_val = 1'b1;
            for (int m = 1; m <= 6; m++) begin
                tick();
                if (capture_en === 1'b1) begin pulses++; if (first < 0) first = m; end
            end
            total += pulses;
            n_total++; if (pulses != 1) $display("FAIL ramp_edge%0d_width: got %0d want 1", e, pulses); else n_pass++;
            n_total++; if (first < 2 || first > 3) $display("FAIL ramp_edge%0d_delay: got %0d want 2..3", e, first); else n_pass++;
            ramp_val = 1'b0;
            for (int m = 0; m < 4; m++) tick();
        end
        n_total++; if (total != 3) $display("FAIL ramp_total: got %0d want 3", total); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ramp_fsm_idle: got %b want 0", busy); else n_pass++;
        // Comparator high while in SAR mode, then switch to ramp mode: no edge.
        adc_mode = 1'b1; ramp_val = 1'b1;
        pulses = 0;
        for (int m = 0; m < 5; m++) begin
            tick();
            if (capture_en === 1'b1) pulses++;
        end
        adc_mode = 1'b0;
        for (int m = 0; m < 5; m++) begin
            tick();
            if (capture_en === 1'b1) pulses++;
        end
        n_total++; if (pulses != 0) $display("FAIL ramp_mode_switch: got %0d want 0", pulses); else n_pass++;
        adc_mode = 1'b1; ramp_val = 1'b0; use_model = 1'b1;
        tick(); tick();
    endtask

    task automatic test_restart();
        int dones, last_done, bad_gap, bad_res;
        dones = 0; last_done = -1; bad_gap = 0; bad_res = 0;
        vin = 8'h3C;
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 1; m <= 130; m++) begin
            if (done === 1'b1) begin
                dones++;
                if (result !== 8'h3C) bad_res++;
                if (last_done >= 0 && (m - last_done) != 41) bad_gap++;
                last_done = m;
            end
            tick();
        end
        n_total++; if (bad_res != 0) $display("FAIL restart_result: got %0d bad results want 0", bad_res); else n_pass++;
`ifdef SAR_CTRL_AUTO_RESTART_EN
        n_total++; if (dones != 3) $display("FAIL restart_done_count: got %0d want 3", dones); else n_pass++;
        n_total++; if (bad_gap != 0) $display("FAIL restart_period: got %0d bad gaps want 0", bad_gap); else n_pass++;
`else
        n_total++; if (dones != 1) $display("FAIL restart_done_count: got %0d want 1", dones); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL restart_idle: got %b want 0", busy); else n_pass++;
`endif
        enable = 1'b0; tick(); enable = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_sar_a5();
        test_abort_mode();
        test_boundary();
        test_abort_reset();
        test_start_held();
        test_ramp();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
